uart_tx_frame: RTL and testbench

- Serial transmitter for the virtual-cable link. It sits directly downstream of the power-on reset stage.
- Its reset input is driven by the inverted power-on reset output, so the transmitter stays quiet until the clock is locked and the 16-cycle reset window has expired.
- It accepts one byte per valid/ready handshake and serialises it as a UART frame: start, data LSB first, optional parity, 1 or 2 stop bits.
- The line idles high.

---
 rtl/uart_tx_frame.sv | 156 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame serialiser: start, 8 data bits LSB first, optional parity, 1-2 stop bits
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("uart_tx_frame: CLKS_PER_BIT must be within 2..65535");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [15:0] LP_CELL_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LP_STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic        LP_HAS_PARITY = (PARITY != 0);
  localparam logic        LP_ODD        = (PARITY == 2);

  state_t      r_state;
  logic [15:0] r_cell;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic        r_tx_out;
  logic        r_tx_busy;
  logic        r_tx_ready;

  state_t      w_state_nxt;
  logic [15:0] w_cell_nxt;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_parity_nxt;
  logic        w_tx_out_nxt;
  logic        w_busy_nxt;
  logic        w_ready_nxt;
  logic        w_fire;
  logic        w_cell_end;

  assign w_fire     = (r_state == S_IDLE) && r_tx_ready && tx_valid;
  assign w_cell_end = (r_cell == LP_CELL_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_cell     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx_out   <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cell     <= w_cell_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_tx_out   <= w_tx_out_nxt;
      r_tx_busy  <= w_busy_nxt;
      r_tx_ready <= w_ready_nxt;
    end
  end

  // r_bit counts data bits in DATA and stop cells in STOP
  always_comb begin
    w_state_nxt  = r_state;
    w_cell_nxt   = r_cell;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    if (r_state != S_IDLE) begin
      w_cell_nxt = w_cell_end ? '0 : r_cell + 16'd1;
    end
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          w_state_nxt  = S_START;
          w_cell_nxt   = '0;
          w_bit_nxt    = '0;
          w_shift_nxt  = tx_data;
          w_parity_nxt = LP_ODD ? ~(^tx_data) : (^tx_data);
        end
      end
      S_START: begin
        if (w_cell_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_cell_end) begin
          if (r_bit == 3'd7) begin
            w_bit_nxt   = '0;
            w_state_nxt = LP_HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (w_cell_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_cell_end) begin
          if (r_bit == LP_STOP_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cell_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it
  always_comb begin
    w_tx_out_nxt = 1'b1;
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_ready_nxt  = (w_state_nxt == S_IDLE);
    case (w_state_nxt)
      S_START:  w_tx_out_nxt = 1'b0;
      S_DATA:   w_tx_out_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_out_nxt = w_parity_nxt;
      default:  w_tx_out_nxt = 1'b1;
    endcase
  end

  assign tx_out   = r_tx_out;
  assign tx_busy  = r_tx_busy;
  assign tx_ready = r_tx_ready;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - four parameterisations of uart_tx_frame checked against a cell-level frame model
module tb_uart_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst;
  logic [3:0] valid;
  logic [7:0] data [4];
  wire  [3:0] ready;
  wire  [3:0] txo;
  wire  [3:0] busy;

  int cfg_cpb [4] = '{4, 4, 4, 2};
  int cfg_par [4] = '{0, 1, 2, 0};
  int cfg_stp [4] = '{1, 2, 2, 1};

  int n_checks = 0;
  int n_pass   = 0;

  bit   m_bits [4][64];
  int   m_len  [4];
  int   m_pos  [4];
  logic m_out  [4];
  logic m_busy [4];
  logic m_ready[4];
  bit   armed = 1'b0;

  uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk_in(clk), .rst_in(rst[0]), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx_out(txo[0]), .tx_busy(busy[0]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u_dut1 (
    .clk_in(clk), .rst_in(rst[1]), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx_out(txo[1]), .tx_busy(busy[1]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u_dut2 (
    .clk_in(clk), .rst_in(rst[2]), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx_out(txo[2]), .tx_busy(busy[2]));
  uart_tx_frame #(.CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1)) u_dut3 (
    .clk_in(clk), .rst_in(rst[3]), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .tx_out(txo[3]), .tx_busy(busy[3]));

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
  endtask

  // Expand a byte into the per-cycle line levels of its whole frame
  function automatic void build(input int i, input logic [7:0] b);
    logic lv [12];
    int   nc;
    int   n;
    lv[0] = 1'b0;
    for (int k = 0; k < 8; k++) lv[k + 1] = b[k];
    nc = 9;
    if (cfg_par[i] != 0) begin
      lv[nc] = (cfg_par[i] == 1) ? ^b : ~(^b);
      nc++;
    end
    for (int s = 0; s < cfg_stp[i]; s++) begin
      lv[nc] = 1'b1;
      nc++;
    end
    n = 0;
    for (int c = 0; c < nc; c++)
      for (int r = 0; r < cfg_cpb[i]; r++) begin
        m_bits[i][n] = lv[c];
        n++;
      end
    m_len[i] = n;
    m_pos[i] = 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst[i]) begin
        m_len[i] = 0; m_pos[i] = 0;
        m_out[i] = 1'b1; m_busy[i] = 1'b0; m_ready[i] = 1'b0;
      end else begin
        if (valid[i] && m_ready[i]) build(i, data[i]);
        if (m_pos[i] < m_len[i]) begin
          m_out[i] = m_bits[i][m_pos[i]];
          m_pos[i]++;
          m_busy[i] = 1'b1; m_ready[i] = 1'b0;
        end else begin
          m_out[i] = 1'b1; m_busy[i] = 1'b0; m_ready[i] = 1'b1;
        end
      end
    end
    if (rst == 4'hF) armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 4; i++) begin
        chk("tx_out", i, txo[i], m_out[i]);
        chk("tx_busy", i, busy[i], m_busy[i]);
        chk("tx_ready", i, ready[i], m_ready[i]);
      end
    end
  end

  // Starts on the first frame cycle; returns at the first idle negedge
  task automatic capture(input int i, input bit toggle, output logic [15:0] cells, output int len);
    cells = '0;
    len   = 0;
    while (busy[i] === 1'b1 && len < 300) begin
      if ((len % cfg_cpb[i]) == 0 && (len / cfg_cpb[i]) < 16) cells[len / cfg_cpb[i]] = txo[i];
      if (toggle) begin
        valid[i] = 1'($urandom_range(0, 1));
        data[i]  = 8'($urandom);
      end
      len++;
      @(negedge clk);
    end
    if (toggle) valid[i] = 1'b0;
  endtask

  task automatic send_capture(input int i, input logic [7:0] b, input bit toggle,
                              output logic [15:0] cells, output int len);
    valid[i] = 1'b1;
    data[i]  = b;
    @(negedge clk);
    valid[i] = 1'b0;
    capture(i, toggle, cells, len);
  endtask

  logic [15:0] cells;
  int          len;

  initial begin
    rst   = 4'hF;
    valid = 4'hF;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    repeat (5) begin
      @(negedge clk);
      chk("rst_ready", 0, ready[0], 0);
      chk("rst_busy", 0, busy[0], 0);
      chk("rst_out", 0, txo[0], 1);
    end
    rst   = 4'h0;
    valid = 4'h0;
    @(negedge clk);
    chk("post_rst_ready", 0, ready[0], 1);

    send_capture(0, 8'hA5, 1'b0, cells, len);
    chk("a5_cells", 0, cells, 16'h034A);
    chk("a5_len", 0, len, 40);
    chk("a5_ready_after", 0, ready[0], 1);

    send_capture(1, 8'h07, 1'b0, cells, len);
    chk("even_cells", 1, cells, 16'h0E0E);
    chk("even_len", 1, len, 48);

    send_capture(2, 8'h07, 1'b0, cells, len);
    chk("odd_cells", 2, cells, 16'h0C0E);
    chk("odd_len", 2, len, 48);

    send_capture(3, 8'h81, 1'b1, cells, len);
    chk("ignored_cells", 3, cells, 16'h0302);
    chk("ignored_len", 3, len, 20);

    valid[0] = 1'b1;
    data[0]  = 8'h55;
    @(negedge clk);
    data[0] = 8'h00;
    capture(0, 1'b0, cells, len);
    chk("b2b_first_cells", 0, cells, 16'h02AA);
    chk("b2b_first_len", 0, len, 40);
    chk("b2b_gap_out", 0, txo[0], 1);
    @(negedge clk);
    chk("b2b_second_busy", 0, busy[0], 1);
    chk("b2b_second_start", 0, txo[0], 0);
    valid[0] = 1'b0;
    capture(0, 1'b0, cells, len);
    chk("b2b_second_cells", 0, cells, 16'h0200);
    chk("b2b_second_len", 0, len, 40);

    valid[0] = 1'b1;
    data[0]  = 8'h00;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("mid_busy", 0, busy[0], 1);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_out", 0, txo[0], 1);
    chk("mid_rst_busy", 0, busy[0], 0);
    chk("mid_rst_ready", 0, ready[0], 0);
    rst[0] = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", 0, ready[0], 1);
    send_capture(0, 8'h81, 1'b0, cells, len);
    chk("after_rst_cells", 0, cells, 16'h0302);
    chk("after_rst_len", 0, len, 40);

    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        rst[i]   = ($urandom_range(0, 399) == 0);
        valid[i] = 1'($urandom_range(0, 1));
        data[i]  = 8'($urandom);
      end
    end
    rst   = 4'h0;
    valid = 4'h0;
    repeat (100) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
